// File: rtl/fix_serializer_if.sv
// fix_serializer_if: tag request, value byte stream and serialized output of the FIX field serializer
interface fix_serializer_if #(
    parameter int TAG_W = 14
);
    logic             tag_valid_i;
    logic             tag_ready_o;
    logic [TAG_W-1:0] tag_i;
    logic             val_valid_i;
    logic             val_ready_o;
    logic [7:0]       val_data_i;
    logic             val_last_i;
    logic [7:0]       data_o;
    logic             valid_o;
    logic             ready_i;
    logic [7:0]       csum_o;
    logic             csum_clr_i;
    logic             busy_o;
    logic             err_o;
    modport master (
        output tag_valid_i, tag_i, val_valid_i, val_data_i, val_last_i, ready_i, csum_clr_i,
        input  tag_ready_o, val_ready_o, data_o, valid_o, csum_o, busy_o, err_o
    );
    modport slave (
        input  tag_valid_i, tag_i, val_valid_i, val_data_i, val_last_i, ready_i, csum_clr_i,
        output tag_ready_o, val_ready_o, data_o, valid_o, csum_o, busy_o, err_o
    );
endinterface

// File: rtl/fix_serializer.sv
// fix_serializer: builds one FIX field "<tag>=<value><SOH>" per request and keeps a running byte checksum
module fix_serializer #(
    parameter int         TAG_W  = 14,
    parameter int         DIGITS = 5,
    parameter logic [7:0] SOH_C  = 8'h01,
    parameter logic [7:0] SEP_C  = 8'h3D
) (
    input logic             clk,
    input logic             rst,
    fix_serializer_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(TAG_W);
    localparam logic [2:0] IDLE = 3'd0, CONV = 3'd1, TAG = 3'd2, SEP = 3'd3, VAL = 3'd4, TERM = 3'd5;
    logic [2:0]       state;
    logic [TAG_W-1:0] sh;
    logic [BW-1:0]    bcd, bcd_adj, bcd_nxt;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx, msd;
    logic [3:0]       digit;
    logic [7:0]       out_byte, csum;
    logic             xfer, err;
    // one double-dabble step, and the most-significant nonzero digit of its result (0 for tag 0)
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++)
            if (bcd[4*d +: 4] > 4'd4) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        bcd_nxt = {bcd_adj[BW-2:0], sh[TAG_W-1]};
        msd = '0;
        for (int d = 0; d < DIGITS; d++)
            if (bcd_nxt[4*d +: 4] != 4'd0) msd = IW'(d);
    end
    assign digit    = 4'(bcd >> (4 * idx));
    assign out_byte = state == TAG ? 8'h30 + {4'h0, digit} :
                      state == SEP ? SEP_C :
                      state == TERM ? SOH_C : bus.val_data_i;
    assign bus.valid_o     = state == TAG || state == SEP || state == TERM || (state == VAL && bus.val_valid_i);
    assign bus.data_o      = bus.valid_o ? out_byte : 8'h00;
    assign bus.val_ready_o = state == VAL && bus.ready_i;
    assign bus.tag_ready_o = state == IDLE;
    assign bus.busy_o      = state != IDLE;
    assign bus.csum_o      = csum;
    assign bus.err_o       = err;
    assign xfer            = bus.valid_o && bus.ready_i;
    // field sequencer: latch tag, convert to BCD, then emit digits, separator, value bytes and SOH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            bcd   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.tag_valid_i) begin
                    sh    <= bus.tag_i;
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= CONV;
                end
                CONV: begin
                    sh  <= sh << 1;
                    bcd <= bcd_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(TAG_W - 1)) begin
                        idx   <= msd;
                        state <= TAG;
                    end
                end
                TAG: if (xfer) begin
                    if (idx == '0) state <= SEP;
                    else idx <= idx - 1'b1;
                end
                SEP:  if (xfer) state <= VAL;
                VAL:  if (xfer && bus.val_last_i) state <= TERM;
                TERM: if (xfer) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // running checksum over transferred bytes, and a flag for value bytes that collide with framing bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'h00;
            err  <= 1'b0;
        end else begin
            csum <= bus.csum_clr_i ? (xfer ? bus.data_o : 8'h00) : (xfer ? csum + bus.data_o : csum);
            err  <= state == VAL && xfer && (bus.val_data_i == SOH_C || bus.val_data_i == SEP_C);
        end
    end
endmodule

// File: tb/tb_fix_serializer.sv
// tb_fix_serializer: directed checks of field framing, latency, backpressure, checksum, err and reset
module tb_fix_serializer;
    typedef logic [7:0] bq_t[$];
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic stall_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   vx = 0;
    int   hold = 0;
    int   si = 0;
    int   stall_n = 0;
    int   stall_bad = 0;
    logic [7:0] hold_d, hold_c;
    logic [7:0] stall_list[2] = '{8'h3D, 8'h58};
    bq_t  got;
    fix_serializer_if #(.TAG_W(14)) bus ();
    fix_serializer dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.ready_i = rdy;
    always #5 clk = ~clk;
    // log every output transfer and every consumed value byte
    always @(posedge clk) begin
        if (bus.valid_o && bus.ready_i) got.push_back(bus.data_o);
        if (bus.val_valid_i && bus.val_ready_o) vx++;
    end
    // downstream stalls: hold ready low 3 cycles when the next listed byte is offered, watching the held output
    always @(posedge clk) begin
        #2;
        if (hold > 0) begin
            stall_n++;
            if (!bus.valid_o || bus.data_o != hold_d || bus.val_ready_o || bus.csum_o != hold_c) stall_bad++;
            hold--;
            if (hold == 0) rdy = 1'b1;
        end else if (stall_en && si < 2 && bus.valid_o && bus.data_o == stall_list[si]) begin
            hold_d = bus.data_o;
            hold_c = bus.csum_o;
            si++;
            rdy  = 1'b0;
            hold = 3;
        end
    end
    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask
    task automatic check_bytes(input string name, input int base, input bq_t e);
        check({name, "_len"}, got.size() - base, e.size());
        for (int j = 0; j < e.size(); j++)
            check($sformatf("%s_b%0d", name, j), (base + j < got.size()) ? got[base + j] : 8'hxx, e[j]);
    endtask
    task automatic run_field(input logic [13:0] t, input bq_t v, output int lat, output int hs_wait, output int errs);
        int k, b, i;
        lat = -1;
        hs_wait = 0;
        errs = 0;
        b = vx;
        bus.tag_i = t;
        bus.tag_valid_i = 1'b1;
        while (!bus.tag_ready_o && hs_wait < 50) begin
            @(posedge clk); #3;
            hs_wait++;
        end
        bus.val_data_i = v[0];
        bus.val_last_i = v.size() == 1;
        bus.val_valid_i = 1'b1;
        @(posedge clk); #3;
        bus.tag_valid_i = 1'b0;
        k = 0;
        while (bus.busy_o && k < 200) begin
            if (bus.valid_o && lat < 0) lat = k + 1;
            if (bus.err_o) errs++;
            @(posedge clk); #3;
            k++;
            i = vx - b;
            if (i < v.size()) begin
                bus.val_data_i = v[i];
                bus.val_last_i = i == v.size() - 1;
            end else bus.val_valid_i = 1'b0;
        end
        if (bus.err_o) errs++;
        check($sformatf("field_%0d_done", t), k < 200, 1);
    endtask
    task automatic clr_pulse();
        bus.csum_clr_i = 1'b1;
        @(posedge clk); #3;
        bus.csum_clr_i = 1'b0;
    endtask
    initial begin
        int lat, hw, er, base;
        bus.tag_valid_i = 1'b0;
        bus.tag_i = '0;
        bus.val_valid_i = 1'b0;
        bus.val_data_i = 8'h00;
        bus.val_last_i = 1'b0;
        bus.csum_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", bus.valid_o, 0);
        check("rst_data", bus.data_o, 8'h00);
        check("rst_csum", bus.csum_o, 8'h00);
        check("rst_busy", bus.busy_o, 0);
        check("rst_vready", bus.val_ready_o, 0);
        check("rst_err", bus.err_o, 0);
        rst = 1'b0;
        @(posedge clk); #3;
        check("rst_tready", bus.tag_ready_o, 1);
        clr_pulse();
        check("t1_clr", bus.csum_o, 8'h00);
        base = got.size();
        run_field(14'd35, '{8'h44}, lat, hw, er);
        check("t1_latency", lat, 15);
        check_bytes("t1", base, '{8'h33, 8'h35, 8'h3D, 8'h44, 8'h01});
        check("t1_csum", bus.csum_o, 8'hEA);
        check("t1_busy", bus.busy_o, 0);
        base = got.size();
        run_field(14'd0, '{8'h31}, lat, hw, er);
        check_bytes("t2", base, '{8'h30, 8'h3D, 8'h31, 8'h01});
        check("t2_csum", bus.csum_o, 8'h89);
        bus.csum_clr_i = 1'b1;
        base = got.size();
        run_field(14'd16383, '{8'h41, 8'h42}, lat, hw, er);
        check_bytes("t3", base, '{8'h31, 8'h36, 8'h33, 8'h38, 8'h33, 8'h3D, 8'h41, 8'h42, 8'h01});
        check("t3_clr_xfer", bus.csum_o, 8'h01);
        bus.csum_clr_i = 1'b0;
        @(posedge clk); #3;
        check("t3_hold", bus.csum_o, 8'h01);
        clr_pulse();
        stall_en = 1'b1;
        base = got.size();
        run_field(14'd8, '{8'h58}, lat, hw, er);
        stall_en = 1'b0;
        check_bytes("t4", base, '{8'h38, 8'h3D, 8'h58, 8'h01});
        check("t4_csum", bus.csum_o, 8'hCE);
        check("t4_stall_cycles", stall_n, 6);
        check("t4_stall_bad", stall_bad, 0);
        clr_pulse();
        base = got.size();
        run_field(14'd8, '{8'h46}, lat, hw, er);
        run_field(14'd9, '{8'h34}, lat, hw, er);
        check("t5_b2b_wait", hw, 0);
        check_bytes("t5", base, '{8'h38, 8'h3D, 8'h46, 8'h01, 8'h39, 8'h3D, 8'h34, 8'h01});
        check("t5_csum", bus.csum_o, 8'h67);
        base = got.size();
        run_field(14'd7, '{8'h3D}, lat, hw, er);
        check("t6_err_pulses", er, 1);
        check_bytes("t6", base, '{8'h37, 8'h3D, 8'h3D, 8'h01});
        check("t6_err_low", bus.err_o, 0);
        clr_pulse();
        bus.tag_i = 14'd5;
        bus.tag_valid_i = 1'b1;
        @(posedge clk); #3;
        bus.tag_valid_i = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        check("t7_val_idle", bus.valid_o, 0);
        check("t7_csum_pre", bus.csum_o, 8'h72);
        bus.val_data_i = 8'h51;
        bus.val_last_i = 1'b1;
        bus.val_valid_i = 1'b1;
        #1;
        check("t7_pass_valid", bus.valid_o, 1);
        check("t7_pass_data", bus.data_o, 8'h51);
        check("t7_pass_vready", bus.val_ready_o, 1);
        rst = 1'b1;
        #1;
        check("t7_rst_valid", bus.valid_o, 0);
        check("t7_rst_data", bus.data_o, 8'h00);
        check("t7_rst_csum", bus.csum_o, 8'h00);
        check("t7_rst_busy", bus.busy_o, 0);
        check("t7_rst_vready", bus.val_ready_o, 0);
        bus.val_valid_i = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #3;
        check("t7_tready", bus.tag_ready_o, 1);
        check("t7_busy", bus.busy_o, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
